// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
//
// Purpose:
//   Drives a 6-digit multiplexed 7-segment display from the six BCD digits of
//   the stopwatch Timer. The digits are captured once per frame so that a
//   Timer update can never produce a display mixing old and new digits. Each
//   digit slot begins with a short all-off gap to suppress ghosting. Optional
//   blink and hour-tens leading-zero blanking are provided.
//
// Ports:
//   Clk         in   1  system clock
//   rst_n       in   1  synchronous active-low reset
//   en          in   1  display enable; low darkens the display and restarts the scan
//   blink       in   1  1: display flashes with a BLINK_FRAMES half-period
//   hr_h..sec_l in   4  BCD digits from the Timer
//   seg         out  7  segments {g,f,e,d,c,b,a}, polarity set by SEG_ACT_LOW
//   dp          out  1  decimal point, polarity set by SEG_ACT_LOW
//   dig_sel     out  6  one-hot digit select, bit0 = sec_l ... bit5 = hr_h,
//                       polarity set by DIG_ACT_LOW
//   frame_tick  out  1  one-cycle pulse on the cycle the snapshot is loaded
//
// Slot index order: 0 sec_l, 1 sec_h, 2 min_l, 3 min_h, 4 hr_l, 5 hr_h.
// SCAN_DIV = CLK_FREQ_HZ / SCAN_HZ must be at least BLANK_CYC + 2.
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int unsigned CLK_FREQ_HZ  = 10_000_000,
    parameter int unsigned SCAN_HZ      = 6_000,
    parameter int unsigned BLANK_CYC    = 16,
    parameter int unsigned BLINK_FRAMES = 500,
    parameter bit          LZ_BLANK     = 1'b1,
    parameter bit          SEG_ACT_LOW  = 1'b1,
    parameter bit          DIG_ACT_LOW  = 1'b1
) (
    input  logic       Clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       blink,
    input  logic [3:0] hr_h,
    input  logic [3:0] hr_l,
    input  logic [3:0] min_h,
    input  logic [3:0] min_l,
    input  logic [3:0] sec_h,
    input  logic [3:0] sec_l,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] dig_sel,
    output logic       frame_tick
);

    localparam int unsigned SCAN_DIV = CLK_FREQ_HZ / SCAN_HZ;
    localparam int unsigned CW       = $clog2(SCAN_DIV);
    localparam int unsigned BW       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // XOR masks turn logical (active-high) values into pin levels; the
    // inactive pin level is therefore the mask itself.
    localparam logic [6:0] SEG_MASK = SEG_ACT_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_MASK  = SEG_ACT_LOW;
    localparam logic [5:0] DIG_MASK = DIG_ACT_LOW ? 6'h3F : 6'h00;

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      idx;
    logic [BW-1:0]   bcnt;
    logic            phase;
    logic [3:0]      snap [6];

    logic [CW-1:0]   cnt_nxt;
    logic            wrap;
    logic            frame_start;
    logic            lit;
    logic [3:0]      cur_digit;
    logic [6:0]      cur_seg;
    logic            cur_dp;

    function automatic logic [6:0] seg7_decode(input logic [3:0] v);
        case (v)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h40;  // non-BCD shows a dash
        endcase
    endfunction

    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        wrap        = 1'b0;
        cnt_nxt     = '0;
        frame_start = 1'b0;
        lit         = 1'b0;
        cur_digit   = '0;
        cur_seg     = '0;
        cur_dp      = 1'b0;

        wrap        = (cnt == CW'(SCAN_DIV - 1));
        cnt_nxt     = wrap ? '0 : cnt + 1'b1;
        frame_start = (cnt == '0) && (idx == 3'd0);

        cur_digit   = snap[idx];
        cur_seg     = seg7_decode(cur_digit);
        cur_dp      = (idx == 3'd2) || (idx == 3'd4);

        // A slot lights only in SHOW, outside the blink-off phase, and not
        // for a zero hour-tens digit when leading-zero blanking is enabled.
        lit = (state == ST_SHOW)
            && !(blink && phase)
            && !(LZ_BLANK && (idx == 3'd5) && (snap[5] == 4'd0));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (!rst_n) begin
            state      <= ST_BLANK;
            cnt        <= '0;
            idx        <= '0;
            bcnt       <= '0;
            phase      <= 1'b0;
            // NOTE: the snapshot array is reset explicitly because its
            // cleared value is part of the defined reset state, not just a
            // don't-care storage element.
            for (int i = 0; i < 6; i++) snap[i] <= '0;
            seg        <= SEG_MASK;
            dp         <= DP_MASK;
            dig_sel    <= DIG_MASK;
            frame_tick <= 1'b0;
        end else if (!en) begin
            // Same as reset, but the snapshot and blink frame count survive.
            state      <= ST_BLANK;
            cnt        <= '0;
            idx        <= '0;
            phase      <= 1'b0;
            seg        <= SEG_MASK;
            dp         <= DP_MASK;
            dig_sel    <= DIG_MASK;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_start;

            if (frame_start) begin
                snap[0] <= sec_l;
                snap[1] <= sec_h;
                snap[2] <= min_l;
                snap[3] <= min_h;
                snap[4] <= hr_l;
                snap[5] <= hr_h;
                if (bcnt == BW'(BLINK_FRAMES - 1)) begin
                    bcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    bcnt <= bcnt + 1'b1;
                end
            end

            cnt   <= cnt_nxt;
            state <= (cnt_nxt < CW'(BLANK_CYC)) ? ST_BLANK : ST_SHOW;
            if (wrap) idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;

            if (lit) begin
                seg     <= cur_seg ^ SEG_MASK;
                dp      <= cur_dp ^ DP_MASK;
                dig_sel <= (6'b000001 << idx) ^ DIG_MASK;
            end else begin
                seg     <= SEG_MASK;
                dp      <= DP_MASK;
                dig_sel <= DIG_MASK;
            end
        end
    end

endmodule
